alu_result_queue: RTL and testbench

//  Downstream stage of the 16-bit ALU. Captures each combinational ALU result
//  (32-bit OUT, cOut, opcode) in a small FIFO. Derives a status-flag nibble per

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_flag_gen.sv | 34 +++
 rtl/alu_result_queue.sv | 107 ++++++++++
 tb/tb_alu_result_queue.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, status-flag bit positions and result width.
// Used by the result queue and, later, the branch unit.
package alu_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_SEL_W  = 3;

    localparam logic [ALU_SEL_W-1:0] ALU_ADD  = 3'b000;
    localparam logic [ALU_SEL_W-1:0] ALU_SUB  = 3'b001;
    localparam logic [ALU_SEL_W-1:0] ALU_AND  = 3'b010;
    localparam logic [ALU_SEL_W-1:0] ALU_OR   = 3'b011;
    localparam logic [ALU_SEL_W-1:0] ALU_NOT  = 3'b100;
    localparam logic [ALU_SEL_W-1:0] ALU_MULT = 3'b101;

    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_H = 3;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational status-flag generator {H,C,N,Z} for one ALU result.
// MULT is judged on the full 32-bit product; every other opcode on the low 16 bits.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int SEL_W  = ALU_SEL_W
) (
    input  logic [DATA_W-1:0] result,
    input  logic              cout,
    input  logic [SEL_W-1:0]  sel,
    output logic [3:0]        flags
);

    logic is_mult;
    logic is_arith;

    assign is_mult  = (sel == SEL_W'(ALU_MULT));
    assign is_arith = (sel == SEL_W'(ALU_ADD)) || (sel == SEL_W'(ALU_SUB));

    always_comb begin
        flags = '0;
        if (is_mult) begin
            flags[FLG_Z] = (result[31:0] == 32'd0);
            flags[FLG_N] = result[31];
            flags[FLG_H] = |result[31:16];
        end else begin
            flags[FLG_Z] = (result[15:0] == 16'd0);
            flags[FLG_N] = result[15];
        end
        flags[FLG_C] = is_arith & cout;
    end

endmodule

// File: rtl/alu_result_queue.sv
// Small FIFO between the ALU and writeback; tags each result with status flags at enqueue.
// Head entry is held in registers so outputs are reset-clean and glitch-free.
module alu_result_queue
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int SEL_W  = ALU_SEL_W,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_result,
    input  logic                       in_cout,
    input  logic [SEL_W-1:0]           in_sel,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_result,
    output logic [SEL_W-1:0]           out_sel,
    output logic [3:0]                 out_flags,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_result [DEPTH];
    logic [SEL_W-1:0]  mem_sel    [DEPTH];
    logic [3:0]        mem_flags  [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [3:0]       in_flags;

    logic             push;
    logic             pop;
    logic [PTR_W-1:0] rd_next;
    logic [CNT_W-1:0] remaining;

    alu_flag_gen #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) u_flag_gen (
        .result (in_result),
        .cout   (in_cout),
        .sel    (in_sel),
        .flags  (in_flags)
    );

    // Handshake: a transfer happens on a rising edge where valid & ready are both high;
    // valid never depends on ready, and in_ready depends only on occupancy and reset.
    assign in_ready  = (count_q != CNT_W'(DEPTH)) & rst_n;
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = count_q;

    assign rd_next   = rd_ptr + PTR_W'(pop);
    assign remaining = count_q - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_result[wr_ptr] <= in_result;
            mem_sel[wr_ptr]    <= in_sel;
            mem_flags[wr_ptr]  <= in_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            wr_ptr  <= wr_ptr + PTR_W'(push);
            rd_ptr  <= rd_next;
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // The pushed entry becomes head only if nothing else remains after this cycle's pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result <= '0;
            out_sel    <= '0;
            out_flags  <= '0;
        end else if (!flush) begin
            if (push && (remaining == '0)) begin
                out_result <= in_result;
                out_sel    <= in_sel;
                out_flags  <= in_flags;
            end else if (remaining != '0) begin
                out_result <= mem_result[rd_next];
                out_sel    <= mem_sel[rd_next];
                out_flags  <= mem_flags[rd_next];
            end
        end
    end

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed bench for alu_result_queue: hand-computed flags, scoreboard queue, negedge monitor.
module tb_alu_result_queue;

    localparam int DATA_W = 32;
    localparam int SEL_W  = 3;
    localparam int DEPTH  = 4;
    localparam int ENT_W  = DATA_W + SEL_W + 4;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_NOT  = 3'b100;
    localparam logic [2:0] OP_MULT = 3'b101;
    localparam logic [2:0] OP_RSV  = 3'b110;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic              in_cout;
    logic [SEL_W-1:0]  in_sel;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [SEL_W-1:0]  out_sel;
    logic [3:0]        out_flags;
    logic [$clog2(DEPTH):0] count;

    logic [3:0]        drv_flags;
    logic [ENT_W-1:0]  exp_q[$];
    int                checks;
    int                failures;

    alu_result_queue #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_cout    (in_cout),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_sel    (out_sel),
        .out_flags  (out_flags),
        .count      (count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver: one cycle of in_valid with a hand-computed expected flag nibble
    task automatic drive(input logic [31:0] r, input logic c, input logic [2:0] s,
                         input logic [3:0] f);
        in_valid  = 1'b1;
        in_result = r;
        in_cout   = c;
        in_sel    = s;
        drv_flags = f;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int i = 0; i < 50 && count != 0; i++) tick();
        out_ready = 1'b0;
        check(name, 32'(count), 32'd0);
    endtask

    // capture: record what the DUT accepts (flush drops everything)
    always @(negedge clk) begin
        if (flush) exp_q.delete();
        else if (rst_n && in_valid && in_ready)
            exp_q.push_back({in_result, in_sel, drv_flags});
    end

    // monitor: compare head on every pop
    always @(negedge clk) begin
        logic [ENT_W-1:0] e;
        if (rst_n && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop actual=%h required=none t=%0t", out_result, $time);
            end else begin
                e = exp_q.pop_front();
                check("pop_result", out_result, 32'(e[ENT_W-1 -: DATA_W]));
                check("pop_sel", 32'(out_sel), 32'(e[6:4]));
                check("pop_flags", 32'(out_flags), 32'(e[3:0]));
            end
        end
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_result = '0;
        in_cout   = 1'b0;
        in_sel    = '0;
        out_ready = 1'b0;
        drv_flags = '0;

        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_sel", 32'(out_sel), 32'd0);
        check("rst_out_flags", 32'(out_flags), 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // SUB zero with carry into empty queue
        drive(32'h0000_0000, 1'b1, OP_SUB, 4'b0101);
        check("sub_out_valid", 32'(out_valid), 32'd1);
        check("sub_flags", 32'(out_flags), 32'd5);
        check("sub_count", 32'(count), 32'd1);
        drain("sub_drain");

        // MULT high half only, then ADD negative low half
        drive(32'h0001_0000, 1'b0, OP_MULT, 4'b1000);
        drive(32'h0000_8000, 1'b0, OP_ADD, 4'b0010);
        check("mult_head_flags", 32'(out_flags), 32'h8);
        check("mult_head_sel", 32'(out_sel), 32'(OP_MULT));
        drain("mult_drain");

        // fill to DEPTH, 5th push refused, then drain in order
        drive(32'h8000_0000, 1'b0, OP_MULT, 4'b1010);
        drive(32'hFFFF_0000, 1'b1, OP_AND, 4'b0001);
        drive(32'h0000_FFFF, 1'b0, OP_NOT, 4'b0010);
        drive(32'h0000_0000, 1'b1, OP_RSV, 4'b0001);
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        drive(32'h1234_5678, 1'b1, OP_OR, 4'b0000);
        check("full_count_after_5th", 32'(count), 32'd4);
        check("full_head_stable", out_result, 32'h8000_0000);
        drain("full_drain");

        // sustained push+pop at count 2 across pointer wrap
        drive(32'h0000_00A0, 1'b1, OP_ADD, 4'b0100);
        drive(32'h0000_00A1, 1'b0, OP_OR, 4'b0000);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'b1;
            in_result = 32'h0000_0100 + 32'(i);
            in_cout   = i[0];
            in_sel    = OP_ADD;
            drv_flags = {1'b0, i[0], 2'b00};
            tick();
            check("stream_count", 32'(count), 32'd2);
        end
        in_valid = 1'b0;
        drain("stream_drain");

        // flush with a same-cycle push at count 3
        drive(32'h0000_0011, 1'b0, OP_AND, 4'b0000);
        drive(32'h0000_0022, 1'b0, OP_AND, 4'b0000);
        drive(32'h0000_0033, 1'b0, OP_AND, 4'b0000);
        check("pre_flush_count", 32'(count), 32'd3);
        flush = 1'b1;
        drive(32'hDEAD_BEEF, 1'b0, OP_OR, 4'b0010);
        flush = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        drive(32'h0000_0044, 1'b1, OP_SUB, 4'b0100);
        check("post_flush_head", out_result, 32'h0000_0044);
        drain("flush_drain");

        // asynchronous reset mid-stream, off the clock edge
        drive(32'h0000_0001, 1'b0, OP_ADD, 4'b0000);
        drive(32'h0000_0002, 1'b0, OP_ADD, 4'b0000);
        drive(32'h0000_0003, 1'b0, OP_ADD, 4'b0000);
        check("pre_rst_count", 32'(count), 32'd3);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        exp_q.delete();
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready_after", 32'(in_ready), 32'd1);
        tick();
        drive(32'h0000_0000, 1'b1, OP_ADD, 4'b0101);
        drain("post_rst_drain");

        repeat (2) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
